// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller:
// operation codes, FSM state encoding and default sizing.
package muldiv_pkg;

    localparam int WIDTH_DEFAULT   = 32;
    localparam int TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        OP_MULT = 2'd0,
        OP_DIV  = 2'd1,
        OP_MTHI = 2'd2,
        OP_MTLO = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // True for operations that hand work to an external arithmetic unit.
    function automatic logic is_unit_op(input op_e op);
        logic r;
        case (op)
            OP_MULT: r = 1'b1;
            OP_DIV:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// HI/LO register controller: sequences the external multiplier/divider,
// owns the HI/LO registers, and serves MFHI/MFLO reads with stall.
module hilo_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             op_ready,
    input  logic             mfhi_req,
    input  logic             mflo_req,
    output logic [WIDTH-1:0] rd_data,
    output logic             stall,
    output logic             mult_init,
    output logic [WIDTH-1:0] mult_a,
    output logic [WIDTH-1:0] mult_b,
    input  logic             mult_end,
    input  logic [WIDTH-1:0] mult_hi,
    input  logic [WIDTH-1:0] mult_lo,
    output logic             div_init,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_end,
    input  logic [WIDTH-1:0] div_hi,
    input  logic [WIDTH-1:0] div_lo,
    input  logic             flush,
    output logic             busy,
    output logic             div_zero,
    output logic             timeout_err
);

    // Counter spans START..timeout; TIMEOUT must be at least 2.
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_r;
    state_e           state_s;
    op_e              op_r;
    op_e              req_op_s;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hi_s;
    logic [WIDTH-1:0] lo_s;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic [CNT_W-1:0] cnt_r;
    logic             mult_init_r;
    logic             div_init_r;
    logic             div_zero_r;
    logic             timeout_err_r;
    logic             accept_s;
    logic             unit_req_s;
    logic             div_by_zero_s;
    logic             unit_end_s;
    logic             timeout_s;

    assign req_op_s      = op_e'(op_code);
    assign op_ready      = (state_r == IDLE) && !flush;
    assign accept_s      = op_valid && op_ready;
    assign unit_req_s    = accept_s && is_unit_op(req_op_s);
    assign div_by_zero_s = (req_op_s == OP_DIV) && (rt_val == {WIDTH{1'b0}});
    // The end pulse on the last allowed WAIT cycle still counts as completion.
    assign timeout_s     = (cnt_r == CNT_LAST) && !unit_end_s;

    assign busy        = (state_r != IDLE);
    assign stall       = busy && (mfhi_req || mflo_req);
    assign mult_init   = mult_init_r;
    assign div_init    = div_init_r;
    assign div_zero    = div_zero_r;
    assign timeout_err = timeout_err_r;
    assign mult_a      = opa_r;
    assign mult_b      = opb_r;
    assign div_a       = opa_r;
    assign div_b       = opb_r;

    // Select the end strobe of the unit owning the current operation.
    always_comb begin
        if (op_r == OP_DIV) begin
            unit_end_s = div_end;
        end else begin
            unit_end_s = mult_end;
        end
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (unit_req_s && !div_by_zero_s) begin
                        state_s = START;
                    end else begin
                        state_s = IDLE;
                    end
                end
                START: state_s = WAIT;
                WAIT: begin
                    if (unit_end_s || timeout_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = WAIT;
                    end
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // HI/LO next values: unit result, MTHI/MTLO, or hold.
    always_comb begin
        hi_s = hi_r;
        lo_s = lo_r;
        if (flush) begin
            hi_s = hi_r;
            lo_s = lo_r;
        end else if ((state_r == WAIT) && unit_end_s) begin
            if (op_r == OP_DIV) begin
                hi_s = div_hi;
                lo_s = div_lo;
            end else begin
                hi_s = mult_hi;
                lo_s = mult_lo;
            end
        end else if (accept_s && (req_op_s == OP_MTHI)) begin
            hi_s = rs_val;
        end else if (accept_s && (req_op_s == OP_MTLO)) begin
            lo_s = rs_val;
        end else begin
            hi_s = hi_r;
            lo_s = lo_r;
        end
    end

    // Read mux shows register contents before any same-cycle write.
    always_comb begin
        if (mfhi_req) begin
            rd_data = hi_r;
        end else if (mflo_req) begin
            rd_data = lo_r;
        end else begin
            rd_data = {WIDTH{1'b0}};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // HI/LO architectural registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else begin
            hi_r <= hi_s;
            lo_r <= lo_s;
        end
    end

    // Operand and op latch; held stable for the whole unit operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r  <= OP_MULT;
            opa_r <= {WIDTH{1'b0}};
            opb_r <= {WIDTH{1'b0}};
        end else if (unit_req_s) begin
            op_r  <= req_op_s;
            opa_r <= rs_val;
            opb_r <= rt_val;
        end else begin
            op_r  <= op_r;
            opa_r <= opa_r;
            opb_r <= opb_r;
        end
    end

    // Watchdog counter: cleared in START, counts WAIT cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == START) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == WAIT) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered single-cycle strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mult_init_r   <= 1'b0;
            div_init_r    <= 1'b0;
            div_zero_r    <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            mult_init_r   <= (state_s == START) && (req_op_s == OP_MULT);
            div_init_r    <= (state_s == START) && (req_op_s == OP_DIV);
            div_zero_r    <= unit_req_s && div_by_zero_s;
            timeout_err_r <= (state_r == WAIT) && !flush && timeout_s;
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Scoreboard bench for hilo_ctrl with behavioural multiplier/divider
// models that can be switched to manually driven end pulses.
module tb_hilo_ctrl;

    localparam int W = 32;
    localparam logic [1:0] C_MULT = 2'd0;
    localparam logic [1:0] C_DIV  = 2'd1;
    localparam logic [1:0] C_MTHI = 2'd2;
    localparam logic [1:0] C_MTLO = 2'd3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic op_valid = 1'b0;
    logic [1:0] op_code = 2'd0;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic op_ready;
    logic mfhi_req = 1'b0;
    logic mflo_req = 1'b0;
    logic [W-1:0] rd_data;
    logic stall;
    logic mult_init, div_init;
    logic [W-1:0] mult_a, mult_b, div_a, div_b;
    logic mult_end, div_end;
    logic [W-1:0] mult_hi, mult_lo, div_hi, div_lo;
    logic flush = 1'b0;
    logic busy, div_zero, timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2*W-1:0] exp_q[$];

    // Unit models
    logic mult_auto = 1'b1;
    logic div_auto = 1'b1;
    int mult_lat = 3;
    int div_lat = 5;
    logic m_man_end = 1'b0;
    logic d_man_end = 1'b0;
    logic [W-1:0] man_hi = 32'hDEADBEEF;
    logic [W-1:0] man_lo = 32'hCAFEF00D;
    logic m_pend = 1'b0, m_end_a = 1'b0, d_pend = 1'b0, d_end_a = 1'b0;
    int m_cnt = 0, d_cnt = 0;
    logic [2*W-1:0] m_res = '0, d_res = '0;
    int n_mult_init = 0, n_div_init = 0;

    assign mult_end = m_end_a | m_man_end;
    assign div_end  = d_end_a | d_man_end;
    assign mult_hi  = mult_auto ? m_res[2*W-1:W] : man_hi;
    assign mult_lo  = mult_auto ? m_res[W-1:0]   : man_lo;
    assign div_hi   = div_auto  ? d_res[2*W-1:W] : man_hi;
    assign div_lo   = div_auto  ? d_res[W-1:0]   : man_lo;

    hilo_ctrl #(.WIDTH(W), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_code(op_code), .rs_val(rs_val), .rt_val(rt_val),
        .op_ready(op_ready),
        .mfhi_req(mfhi_req), .mflo_req(mflo_req), .rd_data(rd_data), .stall(stall),
        .mult_init(mult_init), .mult_a(mult_a), .mult_b(mult_b),
        .mult_end(mult_end), .mult_hi(mult_hi), .mult_lo(mult_lo),
        .div_init(div_init), .div_a(div_a), .div_b(div_b),
        .div_end(div_end), .div_hi(div_hi), .div_lo(div_lo),
        .flush(flush), .busy(busy), .div_zero(div_zero), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mult_init) n_mult_init <= n_mult_init + 1;
        if (div_init)  n_div_init  <= n_div_init + 1;
    end

    always @(posedge clk) begin
        m_end_a <= 1'b0;
        if (mult_init && mult_auto) begin
            m_pend <= 1'b1;
            m_cnt  <= mult_lat;
            m_res  <= $signed({{W{mult_a[W-1]}}, mult_a}) * $signed({{W{mult_b[W-1]}}, mult_b});
        end else if (m_pend) begin
            if (m_cnt == 0) begin
                m_end_a <= 1'b1;
                m_pend  <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        d_end_a <= 1'b0;
        if (div_init && div_auto) begin
            d_pend <= 1'b1;
            d_cnt  <= div_lat;
            if (div_b == '0) d_res <= '1;
            else d_res <= {W'($signed(div_a) % $signed(div_b)), W'($signed(div_a) / $signed(div_b))};
        end else if (d_pend) begin
            if (d_cnt == 0) begin
                d_end_a <= 1'b1;
                d_pend  <= 1'b0;
            end else begin
                d_cnt <= d_cnt - 1;
            end
        end
    end

    task automatic issue(input logic [1:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op_valid = 1'b1; op_code = code; rs_val = a; rt_val = b;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
        mfhi_req = 1'b1; mflo_req = 1'b0; #1 hi = rd_data;
        mfhi_req = 1'b0; mflo_req = 1'b1; #1 lo = rd_data;
        mflo_req = 1'b0; #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] hi, lo;
        reset = 1'b0; mfhi_req = 1'b1; op_valid = 1'b1; op_code = C_MULT; rs_val = 32'd3; rt_val = 32'd4;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, stall, mult_init, div_init, div_zero, timeout_err} !== 6'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 000000", {busy, stall, mult_init, div_init, div_zero, timeout_err});
        end
        n_cmp++;
        if ({mult_a, mult_b} !== 64'd0) begin
            n_bad++; $display("FAIL reset_operands: got %h expected 0", {mult_a, mult_b});
        end
        op_valid = 1'b0; mfhi_req = 1'b0;
        read_hilo(hi, lo);
        n_cmp++;
        if ({hi, lo} !== 64'd0) begin
            n_bad++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({op_ready, busy} !== 2'b10) begin
            n_bad++; $display("FAIL reset_release: got ready/busy %b expected 10", {op_ready, busy});
        end
    endtask

    task automatic test_mult_stall();
        logic [W-1:0] hi, lo;
        logic [2*W-1:0] e;
        int i0, bad_stall;
        mult_auto = 1'b1; mult_lat = 4;
        i0 = n_mult_init; bad_stall = 0;
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
        mfhi_req = 1'b1;
        issue(C_MULT, 32'd7, -32'sd3);
        n_cmp++;
        if ({mult_init, busy, mult_a, mult_b} !== {2'b11, 32'd7, 32'hFFFFFFFD}) begin
            n_bad++; $display("FAIL mult_start: got init/busy %b a=%h b=%h", {mult_init, busy}, mult_a, mult_b);
        end
        for (int i = 0; i < 100 && busy; i++) begin
            n_cmp++;
            if (stall !== 1'b1) begin
                n_bad++; $display("FAIL mult_stall: got %b expected 1 at busy cycle %0d", stall, i);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if ({busy, stall, rd_data} !== {2'b00, 32'hFFFFFFFF}) begin
            n_bad++; $display("FAIL mult_done: got busy/stall %b rd=%h expected 00 ffffffff", {busy, stall}, rd_data);
        end
        n_cmp++;
        if (n_mult_init - i0 !== 1) begin
            n_bad++; $display("FAIL mult_init_count: got %0d expected 1", n_mult_init - i0);
        end
        mfhi_req = 1'b0;
        read_hilo(hi, lo);
        e = exp_q.pop_front();
        n_cmp++;
        if ({hi, lo} !== e) begin
            n_bad++; $display("FAIL mult_result: got %h expected %h", {hi, lo}, e);
        end
    endtask

    task automatic test_div();
        logic [W-1:0] hi, lo;
        logic [2*W-1:0] e;
        bit ok;
        int d0;
        div_auto = 1'b1; div_lat = 6;
        exp_q.push_back({32'd2, 32'd14});
        issue(C_DIV, 32'd100, 32'd7);
        n_cmp++;
        if ({div_init, mult_init, div_a, div_b} !== {2'b10, 32'd100, 32'd7}) begin
            n_bad++; $display("FAIL div_start: got %b a=%h b=%h", {div_init, mult_init}, div_a, div_b);
        end
        wait_idle(100, ok);
        read_hilo(hi, lo);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || {hi, lo} !== e) begin
            n_bad++; $display("FAIL div_result: ok=%0b got %h expected %h", ok, {hi, lo}, e);
        end
        d0 = n_div_init;
        exp_q.push_back({32'd2, 32'd14});
        issue(C_DIV, 32'd5, 32'd0);
        n_cmp++;
        if ({div_zero, busy} !== 2'b10) begin
            n_bad++; $display("FAIL divzero_pulse: got zero/busy %b expected 10", {div_zero, busy});
        end
        @(negedge clk);
        n_cmp++;
        if ({div_zero, busy} !== 2'b00) begin
            n_bad++; $display("FAIL divzero_width: got zero/busy %b expected 00", {div_zero, busy});
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (n_div_init !== d0) begin
            n_bad++; $display("FAIL divzero_noinit: got %0d init pulses expected 0", n_div_init - d0);
        end
        read_hilo(hi, lo);
        e = exp_q.pop_front();
        n_cmp++;
        if ({hi, lo} !== e) begin
            n_bad++; $display("FAIL divzero_hilo: got %h expected %h", {hi, lo}, e);
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [W-1:0] hi, lo;
        logic [2*W-1:0] e;
        int busy_seen;
        busy_seen = 0;
        exp_q.push_back({32'h00001234, 32'h0000ABCD});
        @(negedge clk);
        op_valid = 1'b1; op_code = C_MTHI; rs_val = 32'h1234; mfhi_req = 1'b1;
        #1;
        n_cmp++;
        if (rd_data !== 32'd2) begin
            n_bad++; $display("FAIL mthi_same_cycle_read: got %h expected 2", rd_data);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
            mfhi_req = 1'b0;
            op_code = C_MTLO; rs_val = 32'hABCD;
            if (i > 0) op_valid = 1'b0;
        end
        n_cmp++;
        if (busy_seen !== 0) begin
            n_bad++; $display("FAIL mt_busy: got busy in %0d cycles expected 0", busy_seen);
        end
        read_hilo(hi, lo);
        e = exp_q.pop_front();
        n_cmp++;
        if ({hi, lo} !== e) begin
            n_bad++; $display("FAIL mt_result: got %h expected %h", {hi, lo}, e);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] hi, lo;
        logic [2*W-1:0] e;
        logic signed [2*W-1:0] p;
        bit ok;
        mult_auto = 1'b0;
        exp_q.push_back({32'h00001234, 32'h0000ABCD});
        issue(C_MULT, 32'd9, 32'd9);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL flush_idle: got busy %b expected 0", busy);
        end
        m_man_end = 1'b1;
        @(negedge clk);
        m_man_end = 1'b0;
        @(negedge clk);
        read_hilo(hi, lo);
        e = exp_q.pop_front();
        n_cmp++;
        if ({busy, hi, lo} !== {1'b0, e}) begin
            n_bad++; $display("FAIL flush_late_end: got busy=%b %h expected 0 %h", busy, {hi, lo}, e);
        end
        exp_q.push_back({32'h00001234, 32'h0000ABCD});
        issue(C_MULT, 32'd9, 32'd9);
        repeat (3) @(negedge clk);
        flush = 1'b1; m_man_end = 1'b1;
        @(negedge clk);
        m_man_end = 1'b0;
        op_valid = 1'b1; op_code = C_MTHI; rs_val = 32'h5555;
        #1;
        n_cmp++;
        if ({op_ready, busy} !== 2'b00) begin
            n_bad++; $display("FAIL flush_ready: got ready/busy %b expected 00", {op_ready, busy});
        end
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0;
        read_hilo(hi, lo);
        e = exp_q.pop_front();
        n_cmp++;
        if ({hi, lo} !== e) begin
            n_bad++; $display("FAIL flush_coincident: got %h expected %h", {hi, lo}, e);
        end
        mult_auto = 1'b1; mult_lat = 2;
        p = $signed(-64'sd5) * $signed(64'sd6);
        exp_q.push_back(p);
        issue(C_MULT, -32'sd5, 32'd6);
        n_cmp++;
        if (mult_init !== 1'b1) begin
            n_bad++; $display("FAIL flush_restart_init: got %b expected 1", mult_init);
        end
        wait_idle(100, ok);
        read_hilo(hi, lo);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || {hi, lo} !== e) begin
            n_bad++; $display("FAIL flush_restart_result: ok=%0b got %h expected %h", ok, {hi, lo}, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] hi, lo;
        logic [2*W-1:0] e;
        mult_auto = 1'b0;
        exp_q.push_back(64'd0);
        issue(C_MULT, 32'd3, 32'd3);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, op_ready} !== 2'b01) begin
            n_bad++; $display("FAIL rstmid_abandon: got busy/ready %b expected 01", {busy, op_ready});
        end
        @(negedge clk);
        reset = 1'b1;
        m_man_end = 1'b1;
        @(negedge clk);
        m_man_end = 1'b0;
        @(negedge clk);
        read_hilo(hi, lo);
        e = exp_q.pop_front();
        n_cmp++;
        if ({busy, hi, lo} !== {1'b0, e}) begin
            n_bad++; $display("FAIL rstmid_hilo: got busy=%b %h expected 0 %h", busy, {hi, lo}, e);
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] hi, lo;
        logic [2*W-1:0] e;
        int t;
        bit seen;
        mult_auto = 1'b0;
        exp_q.push_back(64'd0);
        issue(C_MULT, 32'd1, 32'd2);
        t = 0; seen = 1'b0;
        n_cmp++;
        if (mult_init !== 1'b1) begin
            n_bad++; $display("FAIL timeout_init: got %b expected 1", mult_init);
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            t++;
            if (timeout_err) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen || t !== 64) begin
            n_bad++; $display("FAIL timeout_delay: seen=%0b got %0d cycles expected 64", seen, t);
        end
        @(negedge clk);
        n_cmp++;
        if ({timeout_err, op_ready, busy} !== 3'b010) begin
            n_bad++; $display("FAIL timeout_after: got err/ready/busy %b expected 010", {timeout_err, op_ready, busy});
        end
        read_hilo(hi, lo);
        e = exp_q.pop_front();
        n_cmp++;
        if ({hi, lo} !== e) begin
            n_bad++; $display("FAIL timeout_hilo: got %h expected %h", {hi, lo}, e);
        end
    endtask

    task automatic test_foreign_end();
        logic [W-1:0] hi, lo;
        logic [2*W-1:0] e;
        bit ok;
        mult_auto = 1'b0; div_auto = 1'b1; div_lat = 8;
        exp_q.push_back({-32'sd1, -32'sd7});
        issue(C_DIV, -32'sd50, 32'd7);
        repeat (3) @(negedge clk);
        m_man_end = 1'b1;
        @(negedge clk);
        m_man_end = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL foreign_end_busy: got %b expected 1", busy);
        end
        wait_idle(100, ok);
        read_hilo(hi, lo);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || {hi, lo} !== e) begin
            n_bad++; $display("FAIL foreign_end_result: ok=%0b got %h expected %h", ok, {hi, lo}, e);
        end
        exp_q.push_back(e);
        m_man_end = 1'b1;
        @(negedge clk);
        m_man_end = 1'b0;
        @(negedge clk);
        read_hilo(hi, lo);
        e = exp_q.pop_front();
        n_cmp++;
        if ({busy, hi, lo} !== {1'b0, e}) begin
            n_bad++; $display("FAIL idle_end_ignored: got busy=%b %h expected 0 %h", busy, {hi, lo}, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] hi, lo, a, b;
        logic signed [W-1:0] sa, sb;
        logic [2*W-1:0] e;
        logic [1:0] code;
        bit ok;
        mult_auto = 1'b1; div_auto = 1'b1;
        for (int k = 0; k < 10; k++) begin
            code = (k % 2 == 0) ? C_MULT : C_DIV;
            a = $urandom; b = $urandom;
            if (k == 2) a = 32'h80000000;
            if (code == C_DIV && b == 32'd0) b = 32'd1;
            mult_lat = $urandom_range(0, 10);
            div_lat  = $urandom_range(0, 10);
            sa = a; sb = b;
            if (code == C_MULT) e = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
            else e = {W'(sa % sb), W'(sa / sb)};
            exp_q.push_back(e);
            issue(code, a, b);
            wait_idle(100, ok);
            read_hilo(hi, lo);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || {hi, lo} !== e) begin
                n_bad++; $display("FAIL b2b_op%0d code=%0d: ok=%0b got %h expected %h", k, code, ok, {hi, lo}, e);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mult_stall();
        test_div();
        test_mthi_mtlo();
        test_flush();
        test_reset_mid();
        test_timeout();
        test_foreign_end();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum cycles from unit start to its end pulse.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports op_valid in 1, op_code in 2 (0=MULT, 1=DIV, 2=MTHI, 3=MTLO), rs_val in WIDTH, rt_val in WIDTH: operation request.
REQ-006 SHALL have port op_ready  out  1  high when a request is accepted this cycle.
REQ-007 SHALL have ports mfhi_req in 1, mflo_req in 1, rd_data out WIDTH, stall out 1: HI/LO read path.
REQ-008 SHALL have ports mult_init out 1, mult_a out WIDTH, mult_b out WIDTH, mult_end in 1, mult_hi in WIDTH, mult_lo in WIDTH: multiplier handshake.
REQ-009 SHALL have ports div_init out 1, div_a out WIDTH, div_b out WIDTH, div_end in 1, div_hi in WIDTH, div_lo in WIDTH: divider handshake.
REQ-010 SHALL have ports flush in 1 (cancel operation), busy out 1, div_zero out 1 (pulse), timeout_err out 1 (pulse).

Function
REQ-011 SHALL implement FSM states IDLE, START, WAIT.
REQ-012 op_ready SHALL equal (state==IDLE && !flush).
- A request is accepted on a rising edge with op_valid && op_ready.
REQ-013 MULT/DIV accept SHALL latch rs_val and rt_val into the operand registers.
- Next state is START, except DIV with rt_val==0 (REQ-019).
REQ-014 In START, mult_init or div_init (per the latched op) SHALL be high for exactly one cycle; the next state is WAIT.
- mult_a/mult_b and div_a/div_b SHALL carry the latched operands whenever busy.
REQ-015 In WAIT, the edge on which the selected unit's end input is sampled high SHALL load HI/LO from its hi/lo outputs and return to IDLE.
- End pulses from the non-selected unit, or received in IDLE or START, SHALL be ignored.
REQ-016 MTHI/MTLO accept SHALL write rs_val into HI/LO on that edge; the FSM SHALL remain in IDLE.
REQ-017 busy SHALL be (state != IDLE).
- stall SHALL be combinational: busy && (mfhi_req || mflo_req).
REQ-018 rd_data SHALL be HI when mfhi_req, else LO when mflo_req, else 0.
- It reflects the register value before any same-cycle write.
REQ-019 DIV with rt_val==0 SHALL pulse div_zero for one cycle after the accept edge.
- The divider SHALL not be started, HI/LO SHALL remain unchanged, and the FSM SHALL stay in IDLE.
REQ-020 A cycle counter SHALL clear on START and increment in WAIT.
- On reaching TIMEOUT without an end pulse: one-cycle timeout_err, HI/LO unchanged, return to IDLE.
REQ-021 flush high SHALL force IDLE on the next edge from any state, with no HI/LO update, even if an end pulse is coincident.
- A later operation SHALL restart the unit via its init pulse.
REQ-022 A signed WIDTH x WIDTH product SHALL map high word to HI and low word to LO.
- For division, quotient SHALL go to LO and remainder to HI, as supplied by the unit.

Reset
REQ-023 While reset==0: state=IDLE, HI=LO=0, operand registers=0, counter=0.
- Outputs: mult_init=div_init=div_zero=timeout_err=0, busy=0, stall=0.
REQ-024 Reset asserted mid-operation SHALL abandon the operation immediately.
- A unit end pulse arriving after reset release SHALL be ignored (FSM is in IDLE).

Structure
REQ-025 Op-code constants, FSM state encoding and the default TIMEOUT SHALL live in shared package muldiv_pkg.
REQ-026 No sub-module SHALL be instantiated; the multiplier and divider are external and connected at CPU top level.

Verification
REQ-027 MULT rs=7, rt=-3 -> one-cycle mult_init after accept; after mult_end: HI=0xFFFFFFFF, LO=0xFFFFFFEB, busy=0.
REQ-028 DIV rs=100, rt=7 -> after div_end: LO=14, HI=2.
- DIV rs=5, rt=0 -> div_zero pulse, no div_init, HI/LO unchanged.
REQ-029 mfhi_req held during a MULT -> stall=1 every busy cycle.
- Cycle after completion -> stall=0, rd_data=new HI.
REQ-030 MTHI 0x1234 then MTLO 0xABCD on consecutive cycles -> HI=0x1234, LO=0xABCD, busy never high.
REQ-031 flush at WAIT cycle 10 of a MULT, then a late mult_end -> HI/LO keep prior values, state IDLE.
- Same for reset mid-WAIT -> HI=LO=0.
REQ-032 Unit model that never pulses end, TIMEOUT=64 -> timeout_err one pulse 64 cycles after START, op_ready=1 the next cycle.
